// File: rtl/proc_trace_driver_pkg.sv
// Shared cache-side types plus the trace ROM entry format and the replay FSM states.
package proc_trace_driver_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ERR_W      = 16;

    typedef struct packed {
        logic                  cs;
        logic                  rw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  flush;
    } processor_request_t;

    typedef struct packed {
        logic hold_cpu;
    } processor_response_t;

    typedef enum logic [1:0] {
        OP_LD  = 2'd0,
        OP_ST  = 2'd1,
        OP_LDC = 2'd2,
        OP_END = 2'd3
    } trace_op_t;

    typedef struct packed {
        trace_op_t             op;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } trace_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_ROM,
        ST_ISSUE,
        ST_WAIT_HOLD,
        ST_FLUSH,
        ST_FLUSH_WAIT,
        ST_DONE
    } drv_state_t;

    // Request word that asks the cache to write back and invalidate everything.
    function automatic processor_request_t flush_req();
        processor_request_t r;
        r       = '0;
        r.cs    = 1'b1;
        r.flush = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/trace_checker.sv
// Captures load data on request completion and counts load-compare mismatches (saturating).
module trace_checker
    import proc_trace_driver_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  capture,
    input  logic                  check,
    input  logic [DATA_WIDTH-1:0] expected,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [ERR_W-1:0]      err_count
);

    logic                  pend;
    logic [DATA_WIDTH-1:0] cap_data;
    logic [DATA_WIDTH-1:0] exp_data;

    // Compare one cycle after capture so the comparator sits behind a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            cap_data  <= '0;
            exp_data  <= '0;
            err_count <= '0;
        end else begin
            pend <= capture && check && !clr;
            if (capture) begin
                cap_data <= load_data;
                exp_data <= expected;
            end
            if (clr) begin
                err_count <= '0;
            end else if (pend && (cap_data != exp_data) && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/proc_trace_driver.sv
// Replays a trace ROM as cache requests, stalls on hold_cpu and finishes with a flush.
// Define SELF_CHECK_EN to compare OP_LDC load data and count mismatches in err_count.
module proc_trace_driver
    import proc_trace_driver_pkg::*;
#(
    parameter int unsigned TRACE_AW = 10,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic [TRACE_AW-1:0]              trace_addr,
    input  logic [$bits(trace_entry_t)-1:0]  trace_entry,
    output processor_request_t               proc_req,
    input  processor_response_t              proc_res,
    input  logic [DATA_WIDTH-1:0]            proc_res_data,
    output logic                             busy,
    output logic                             done,
    output logic                             timeout,
    output logic [TRACE_AW:0]                op_count,
    output logic [ERR_W-1:0]                 err_count
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    drv_state_t          state;
    logic [TRACE_AW-1:0] ptr;
    logic [WAIT_W-1:0]   wait_cnt;
    trace_op_t           cur_op;
    trace_entry_t        entry_c;
    logic                hold_c;
    logic                wait_max_c;
    logic [1:0]          rst_sync;
    logic                rst_n;

    // Reset asserts asynchronously and is released on a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    assign entry_c    = trace_entry_t'(trace_entry);
    assign hold_c     = proc_res.hold_cpu;
    assign wait_max_c = (wait_cnt == WAIT_W'(MAX_WAIT - 1));
    assign trace_addr = ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            wait_cnt <= '0;
            cur_op   <= OP_LD;
            proc_req <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            op_count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        ptr      <= '0;
                        op_count <= '0;
                        timeout  <= 1'b0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_WAIT_ROM;
                ST_WAIT_ROM: begin
                    if (entry_c.op == OP_END) begin
                        proc_req <= flush_req();
                        state    <= ST_FLUSH;
                    end else begin
                        cur_op         <= entry_c.op;
                        proc_req.cs    <= 1'b1;
                        proc_req.rw    <= (entry_c.op == OP_ST);
                        proc_req.addr  <= entry_c.addr;
                        proc_req.data  <= entry_c.data;
                        proc_req.flush <= 1'b0;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT_HOLD;
                end
                ST_WAIT_HOLD: begin
                    if (!hold_c) begin
                        if (op_count != '1) begin
                            op_count <= op_count + 1'b1;
                        end
                        // Last ROM slot done: the trace has wrapped, so close it out.
                        if (ptr == '1) begin
                            proc_req <= flush_req();
                            state    <= ST_FLUSH;
                        end else begin
                            proc_req <= '0;
                            ptr      <= ptr + 1'b1;
                            state    <= ST_FETCH;
                        end
                    end else if (wait_max_c) begin
                        timeout  <= 1'b1;
                        proc_req <= flush_req();
                        state    <= ST_FLUSH;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    wait_cnt <= '0;
                    state    <= ST_FLUSH_WAIT;
                end
                ST_FLUSH_WAIT: begin
                    // A stuck flush is bounded too, so replay always reaches DONE.
                    if (!hold_c || wait_max_c) begin
                        if (hold_c) begin
                            timeout <= 1'b1;
                        end
                        proc_req <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SELF_CHECK_EN
    logic load_done_c;
    logic start_ok_c;

    assign load_done_c = (state == ST_WAIT_HOLD) && !hold_c && !proc_req.rw;
    assign start_ok_c  = start && ((state == ST_IDLE) || (state == ST_DONE));

    trace_checker u_trace_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_ok_c),
        .capture   (load_done_c),
        .check     (cur_op == OP_LDC),
        .expected  (proc_req.data),
        .load_data (proc_res_data),
        .err_count (err_count)
    );
`else
    logic unused_check;

    assign unused_check = ^{proc_res_data, cur_op};
    assign err_count    = '0;
`endif

endmodule

// File: tb/tb_proc_trace_driver.sv
// Scoreboard bench: expected cache requests are queued as the ROM is written, then popped as issued.
module tb_proc_trace_driver;
    import proc_trace_driver_pkg::*;

    localparam int unsigned TAW = 3;
    localparam int unsigned MW  = 8;
    localparam int unsigned EW  = $bits(trace_entry_t);
`ifdef SELF_CHECK_EN
    localparam int unsigned LDC_ERR = 1;
`else
    localparam int unsigned LDC_ERR = 0;
`endif

    logic                  clk   = 1'b0;
    logic                  rst   = 1'b0;
    logic                  start = 1'b0;
    logic [TAW-1:0]        trace_addr;
    logic [EW-1:0]         trace_entry = '0;
    processor_request_t    proc_req;
    processor_response_t   proc_res      = '0;
    logic [DATA_WIDTH-1:0] proc_res_data = '0;
    logic                  busy;
    logic                  done;
    logic                  timeout;
    logic [TAW:0]          op_count;
    logic [ERR_W-1:0]      err_count;

    trace_entry_t          rom [2**TAW];
    processor_request_t    exp_q[$];
    processor_request_t    cur_exp  = '0;
    processor_request_t    prev_req = '0;
    logic [DATA_WIDTH-1:0] cmem [logic [ADDR_WIDTH-1:0]];
    int                    vectors     = 0;
    int                    miscompares = 0;
    int                    ld_stall    = 0;
    int                    hold_rem    = 0;
    bit                    stuck       = 1'b0;

    proc_trace_driver #(.TRACE_AW(TAW), .MAX_WAIT(MW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .trace_addr    (trace_addr),
        .trace_entry   (trace_entry),
        .proc_req      (proc_req),
        .proc_res      (proc_res),
        .proc_res_data (proc_res_data),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .op_count      (op_count),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    // Synchronous trace ROM: data valid the cycle after the address.
    always @(posedge clk) trace_entry <= EW'(rom[trace_addr]);

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Cache model and request monitor, all on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            hold_rem = 0;
            prev_req = '0;
        end else begin
            if (proc_req.cs && (!prev_req.cs || proc_req != prev_req)) begin
                if (exp_q.size() == 0) begin
                    check_eq("req_unexpected", 96'(proc_req), 96'(0));
                    cur_exp = '0;
                end else begin
                    cur_exp = exp_q.pop_front();
                end
                if (proc_req.rw && !proc_req.flush) cmem[proc_req.addr] = proc_req.data;
                hold_rem = (!proc_req.rw && !proc_req.flush && ld_stall > 0) ? ld_stall + 1 : 0;
            end else if (hold_rem > 0) begin
                hold_rem--;
            end
            if (proc_req.cs) check_eq("req", 96'(proc_req), 96'(cur_exp));
            prev_req = proc_req;
        end
        proc_res = processor_response_t'(stuck || (hold_rem != 0));
        if (proc_res.hold_cpu) proc_res_data = 32'hBAD0_BAD0;
        else if (cmem.exists(proc_req.addr)) proc_res_data = cmem[proc_req.addr];
        else proc_res_data = '0;
    end

    task automatic clear_rom();
        for (int i = 0; i < 2**TAW; i++) rom[i] = '{op: OP_END, addr: '0, data: '0};
    endtask

    task automatic put(input int idx, input trace_op_t op, input logic [31:0] a,
                       input logic [31:0] d, input bit exp_issue);
        rom[idx] = '{op: op, addr: a, data: d};
        if (exp_issue) exp_q.push_back('{cs: 1'b1, rw: (op == OP_ST), addr: a, data: d, flush: 1'b0});
    endtask

    task automatic push_flush();
        exp_q.push_back(flush_req());
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(output int cyc);
        pulse_start();
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic post(input string name, input int ops, input int errs, input bit to);
        repeat (2) @(negedge clk);
        check_eq({name, "_done"}, 96'(done), 96'(1));
        check_eq({name, "_busy"}, 96'(busy), 96'(0));
        check_eq({name, "_ops"}, 96'(op_count), 96'(ops));
        check_eq({name, "_err"}, 96'(err_count), 96'(errs));
        check_eq({name, "_timeout"}, 96'(timeout), 96'(to));
        check_eq({name, "_queue_left"}, 96'(exp_q.size()), 96'(0));
        check_eq({name, "_cs_idle"}, 96'(proc_req), 96'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  found;

        clear_rom();
        repeat (3) @(negedge clk);
        check_eq("rst_req", 96'(proc_req), 96'(0));
        check_eq("rst_busy", 96'(busy), 96'(0));
        check_eq("rst_done", 96'(done), 96'(0));
        check_eq("rst_timeout", 96'(timeout), 96'(0));
        check_eq("rst_ops", 96'(op_count), 96'(0));
        check_eq("rst_err", 96'(err_count), 96'(0));
        check_eq("rst_addr", 96'(trace_addr), 96'(0));
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Store then matching load-compare, no stalls.
        clear_rom();
        put(0, OP_ST, 32'h10, 32'hDEAD_BEEF, 1'b1);
        put(1, OP_LDC, 32'h10, 32'hDEAD_BEEF, 1'b1);
        push_flush();
        run(cyc);
        check_eq("t1_cycles", 96'(cyc), 96'(1 + 4 * 2 + 4));
        post("t1", 2, 0, 1'b0);

        // Load stalled six cycles; junk data until release.
        clear_rom();
        put(0, OP_ST, 32'h20, 32'hCAFE_F00D, 1'b1);
        put(1, OP_LDC, 32'h20, 32'hCAFE_F00D, 1'b1);
        push_flush();
        ld_stall = 6;
        run(cyc);
        ld_stall = 0;
        check_eq("t2_cycles", 96'(cyc), 96'(1 + 4 * 2 + 6 + 4));
        post("t2", 2, 0, 1'b0);

        // Load-compare against a deliberately wrong cache value.
        clear_rom();
        cmem[32'h30] = 32'h1234_5679;
        put(0, OP_LDC, 32'h30, 32'h1234_5678, 1'b1);
        push_flush();
        run(cyc);
        post("t3", 1, LDC_ERR, 1'b0);

        // hold_cpu stuck: request abandoned after MAX_WAIT, flush still issued.
        clear_rom();
        put(0, OP_LD, 32'h40, 32'h0, 1'b1);
        put(1, OP_ST, 32'h44, 32'h1, 1'b0);
        push_flush();
        stuck = 1'b1;
        run(cyc);
        stuck = 1'b0;
        check_eq("t4_cycles", 96'(cyc), 96'(1 + 3 + MW + 1 + MW));
        post("t4", 0, 0, 1'b1);

        // Full ROM with no END: wraps after eight ops.
        clear_rom();
        for (int i = 0; i < 2**TAW; i++) begin
            put(i, (i % 2 == 0) ? OP_ST : OP_LD, 32'(32'h100 + 4 * (i / 2)), 32'(i * 32'h1111_1111), 1'b1);
        end
        push_flush();
        run(cyc);
        check_eq("t5_cycles", 96'(cyc), 96'(1 + 4 * 8 + 2));
        post("t5", 8, 0, 1'b0);

        // Reset while a load is stalled, then restart from entry 0.
        clear_rom();
        put(0, OP_ST, 32'h50, 32'hA5A5_A5A5, 1'b1);
        put(1, OP_LD, 32'h54, 32'h0, 1'b1);
        ld_stall = 6;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (proc_req.cs && !proc_req.rw) found = 1'b1;
        end
        check_eq("t6_load_seen", 96'(found), 96'(1));
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("t6_cs_async", 96'(proc_req.cs), 96'(0));
        check_eq("t6_busy_async", 96'(busy), 96'(0));
        @(negedge clk);
        rst = 1'b1;
        ld_stall = 0;
        exp_q.delete();
        repeat (4) @(negedge clk);
        check_eq("t6_idle_done", 96'(done), 96'(0));
        put(0, OP_ST, 32'h50, 32'hA5A5_A5A5, 1'b1);
        put(1, OP_LD, 32'h54, 32'h0, 1'b1);
        push_flush();
        run(cyc);
        post("t6", 2, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
